pipe_hazard_ctrl: RTL and testbench

Central pipeline controller for the 16-bit core. It detects load-use hazards and generates the forwarding selects for the stage-two ALU operand muxes. It sequences multi-cycle ALU operations (MUL/DIV) by holding the pipeline, and drains the pipeline on a HALT instruction. It drives the `stall` and `halt_sys` signals that freeze the stage A/B flip-flops.

---
 rtl/pipe_hazard_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Central pipeline controller for the 16-bit core.
//               - Detects load-use hazards between decode and stage two and
//                 inserts a one-cycle stall plus bubble.
//               - Produces forwarding selects for the two stage-two ALU
//                 operand muxes (stage two has priority over stage three).
//               - Holds the pipeline while a multi-cycle MUL/DIV executes.
//               - Drains the pipeline on HALT and then halts for good.
// Ports       :
//   clk                 system clock, rising edge
//   rst_n               asynchronous active-low reset
//   i_id_*              decode-stage instruction attributes
//   i_ex_*              stage-two instruction attributes
//   i_mem_*             stage-three instruction attributes
//   o_fwd_a/o_fwd_b     operand source: 00 regfile, 01 stage two, 10 stage three
//   o_stall             freeze PC, stage A and stage B flops
//   o_bubble            load a NOP into stage B this edge
//   o_alu_busy          multi-cycle ALU operation in progress
//   o_halt_sys          system halted (sticky until reset)
// Parameters  :
//   MULDIV_CYCLES       ALU cycles of a MUL/DIV, legal range 1..15
//   RAW                 register address width
// Revision    : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int MULDIV_CYCLES = 4,
    parameter int RAW           = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_id_valid,
    input  logic [RAW-1:0] i_id_rs1,
    input  logic [RAW-1:0] i_id_rs2,
    input  logic           i_id_use1,
    input  logic           i_id_use2,
    input  logic           i_id_multi,
    input  logic           i_id_halt,
    input  logic           i_ex_valid,
    input  logic           i_ex_reg_wr,
    input  logic           i_ex_is_load,
    input  logic [RAW-1:0] i_ex_rd,
    input  logic           i_mem_valid,
    input  logic           i_mem_reg_wr,
    input  logic [RAW-1:0] i_mem_rd,
    output logic [1:0]     o_fwd_a,
    output logic [1:0]     o_fwd_b,
    output logic           o_stall,
    output logic           o_bubble,
    output logic           o_alu_busy,
    output logic           o_halt_sys
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_ST_RUN   = 2'd0;
    localparam logic [1:0] c_ST_MULTI = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;
    localparam logic [1:0] c_ST_HALT  = 2'd3;

    localparam logic [1:0] c_FWD_RF  = 2'b00;
    localparam logic [1:0] c_FWD_EX  = 2'b01;
    localparam logic [1:0] c_FWD_MEM = 2'b10;

    // A single-cycle MUL/DIV needs no hold, so MULTI is unreachable then.
    localparam logic       c_MULTI_EN    = (MULDIV_CYCLES > 1);
    localparam logic [3:0] c_MULTI_LOAD  = 4'(MULDIV_CYCLES - 1);
    // Two bubble cycles let the two older instructions retire before halting.
    localparam logic [3:0] c_DRAIN_LOAD  = 4'd2;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0] r_state;
    logic [3:0] r_cnt;
    logic [1:0] w_state_nxt;
    logic [3:0] w_cnt_nxt;

    // ------------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------------
    logic w_in_run;
    logic w_ex_load_wr;
    logic w_rs1_match_ex;
    logic w_rs2_match_ex;
    logic w_hazard;

    assign w_in_run       = (r_state == c_ST_RUN);
    assign w_ex_load_wr   = i_ex_valid & i_ex_is_load & i_ex_reg_wr & (i_ex_rd != '0);
    assign w_rs1_match_ex = i_id_use1 & (i_id_rs1 == i_ex_rd);
    assign w_rs2_match_ex = i_id_use2 & (i_id_rs2 == i_ex_rd);
    assign w_hazard       = w_in_run & i_id_valid & w_ex_load_wr
                          & (w_rs1_match_ex | w_rs2_match_ex);

    // Decode-side control is only sampled when the instruction actually
    // leaves decode this edge: RUN with no hazard stall.
    logic w_id_accept;
    assign w_id_accept = w_in_run & i_id_valid & ~w_hazard;

    // ------------------------------------------------------------------------
    // Forwarding
    // ------------------------------------------------------------------------
    // A load in stage two has no result yet; that case is covered by the
    // hazard stall, after which the load forwards from stage three.
    logic w_ex_fwd_ok;
    logic w_mem_fwd_ok;

    assign w_ex_fwd_ok  = i_ex_valid & i_ex_reg_wr & ~i_ex_is_load & (i_ex_rd != '0);
    assign w_mem_fwd_ok = i_mem_valid & i_mem_reg_wr & (i_mem_rd != '0);

    function automatic logic [1:0] fwd_sel(input logic [RAW-1:0] rs,
                                           input logic [RAW-1:0] ex_rd,
                                           input logic [RAW-1:0] mem_rd,
                                           input logic           ex_ok,
                                           input logic           mem_ok);
        logic [1:0] sel;
        sel = c_FWD_RF;
        if (ex_ok && (ex_rd == rs)) begin
            sel = c_FWD_EX;
        end else if (mem_ok && (mem_rd == rs)) begin
            sel = c_FWD_MEM;
        end
        return sel;
    endfunction

    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;

    always_comb begin
        w_fwd_a = fwd_sel(i_id_rs1, i_ex_rd, i_mem_rd, w_ex_fwd_ok, w_mem_fwd_ok);
        w_fwd_b = fwd_sel(i_id_rs2, i_ex_rd, i_mem_rd, w_ex_fwd_ok, w_mem_fwd_ok);
        if (r_state == c_ST_HALT) begin
            w_fwd_a = c_FWD_RF;
            w_fwd_b = c_FWD_RF;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_ST_RUN: begin
                // HALT wins over MUL/DIV if decode flags both.
                if (w_id_accept && i_id_halt) begin
                    w_state_nxt = c_ST_DRAIN;
                    w_cnt_nxt   = c_DRAIN_LOAD;
                end else if (w_id_accept && i_id_multi && c_MULTI_EN) begin
                    w_state_nxt = c_ST_MULTI;
                    w_cnt_nxt   = c_MULTI_LOAD;
                end
            end
            c_ST_MULTI: begin
                if (r_cnt == 4'd1) begin
                    w_state_nxt = c_ST_RUN;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt   = r_cnt - 4'd1;
                end
            end
            c_ST_DRAIN: begin
                if (r_cnt == 4'd1) begin
                    w_state_nxt = c_ST_HALT;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt   = r_cnt - 4'd1;
                end
            end
            c_ST_HALT: begin
                w_state_nxt = c_ST_HALT;
                w_cnt_nxt   = 4'd0;
            end
            default: begin
                w_state_nxt = c_ST_RUN;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_RUN;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    logic w_stall;
    logic w_bubble;

    always_comb begin
        w_stall  = 1'b0;
        w_bubble = 1'b0;
        case (r_state)
            c_ST_RUN: begin
                w_stall  = w_hazard;
                w_bubble = w_hazard;
            end
            c_ST_MULTI: begin
                w_stall  = 1'b1;
            end
            c_ST_DRAIN: begin
                // PC and stage A are held externally; stage B takes NOPs.
                w_bubble = 1'b1;
            end
            c_ST_HALT: begin
                w_stall  = 1'b1;
            end
            default: begin
                w_stall  = 1'b0;
                w_bubble = 1'b0;
            end
        endcase
    end

    // All outputs are forced low while reset is held, even though most of
    // them are combinational from the inputs.
    assign o_fwd_a    = rst_n ? w_fwd_a : c_FWD_RF;
    assign o_fwd_b    = rst_n ? w_fwd_b : c_FWD_RF;
    assign o_stall    = rst_n & w_stall;
    assign o_bubble   = rst_n & w_bubble;
    assign o_alu_busy = rst_n & (r_state == c_ST_MULTI);
    assign o_halt_sys = rst_n & (r_state == c_ST_HALT);

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Directed bench for pipe_hazard_ctrl. Two instances share all
//               inputs: one with MULDIV_CYCLES=4, one with MULDIV_CYCLES=1.
//               Expected output vectors are queued when a step is driven and
//               popped at the opposite clock edge for comparison.
//               Vector layout: {fwd_a, fwd_b, stall, bubble, alu_busy, halt}.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int RAW = 4;

    logic           clk;
    logic           rst_n;
    logic           id_valid, id_use1, id_use2, id_multi, id_halt;
    logic [RAW-1:0] id_rs1, id_rs2;
    logic           ex_valid, ex_reg_wr, ex_is_load;
    logic [RAW-1:0] ex_rd;
    logic           mem_valid, mem_reg_wr;
    logic [RAW-1:0] mem_rd;

    logic [1:0] fwd_a4, fwd_b4, fwd_a1, fwd_b1;
    logic       stall4, bubble4, busy4, halt4;
    logic       stall1, bubble1, busy1, halt1;

    pipe_hazard_ctrl #(.MULDIV_CYCLES(4), .RAW(RAW)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .i_id_valid(id_valid), .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
        .i_id_use1(id_use1), .i_id_use2(id_use2),
        .i_id_multi(id_multi), .i_id_halt(id_halt),
        .i_ex_valid(ex_valid), .i_ex_reg_wr(ex_reg_wr), .i_ex_is_load(ex_is_load),
        .i_ex_rd(ex_rd),
        .i_mem_valid(mem_valid), .i_mem_reg_wr(mem_reg_wr), .i_mem_rd(mem_rd),
        .o_fwd_a(fwd_a4), .o_fwd_b(fwd_b4), .o_stall(stall4), .o_bubble(bubble4),
        .o_alu_busy(busy4), .o_halt_sys(halt4)
    );

    pipe_hazard_ctrl #(.MULDIV_CYCLES(1), .RAW(RAW)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .i_id_valid(id_valid), .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
        .i_id_use1(id_use1), .i_id_use2(id_use2),
        .i_id_multi(id_multi), .i_id_halt(id_halt),
        .i_ex_valid(ex_valid), .i_ex_reg_wr(ex_reg_wr), .i_ex_is_load(ex_is_load),
        .i_ex_rd(ex_rd),
        .i_mem_valid(mem_valid), .i_mem_reg_wr(mem_reg_wr), .i_mem_rd(mem_rd),
        .o_fwd_a(fwd_a1), .o_fwd_b(fwd_b1), .o_stall(stall1), .o_bubble(bubble1),
        .o_alu_busy(busy1), .o_halt_sys(halt1)
    );

    logic [7:0] w_obs4, w_obs1;
    assign w_obs4 = {fwd_a4, fwd_b4, stall4, bubble4, busy4, halt4};
    assign w_obs1 = {fwd_a1, fwd_b1, stall1, bubble1, busy1, halt1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [7:0] e4;
        logic [7:0] e1;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;

    localparam logic [7:0] E0 = 8'h00;

    function automatic logic [7:0] ev(input logic [1:0] fa, input logic [1:0] fb,
                                      input logic s, input logic b,
                                      input logic a, input logic h);
        return {fa, fb, s, b, a, h};
    endfunction

    // Queue the expectation for the step just driven, then compare at the
    // falling edge and advance to just after the next rising edge.
    task automatic check(input string tag, input logic [7:0] e4, input logic [7:0] e1);
        exp_t it;
        sb.push_back('{tag: tag, e4: e4, e1: e1});
        @(negedge clk);
        it = sb.pop_front();
        n_total++;
        assert (w_obs4 === it.e4) n_pass++;
        else $error("FAIL %s_m4 observed=%b expected=%b", it.tag, w_obs4, it.e4);
        n_total++;
        assert (w_obs1 === it.e1) n_pass++;
        else $error("FAIL %s_m1 observed=%b expected=%b", it.tag, w_obs1, it.e1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_use1 = 0; id_use2 = 0; id_multi = 0; id_halt = 0;
        id_rs1 = '0; id_rs2 = '0;
        ex_valid = 0; ex_reg_wr = 0; ex_is_load = 0; ex_rd = '0;
        mem_valid = 0; mem_reg_wr = 0; mem_rd = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst_n = 1'b0;
        @(posedge clk);
        #1;

        // Reset held with a load-use pattern on the inputs: outputs stay 0.
        ex_valid = 1; ex_reg_wr = 1; ex_is_load = 1; ex_rd = 4'd3;
        id_valid = 1; id_rs1 = 4'd3; id_use1 = 1; id_rs2 = 4'd1; id_use2 = 1;
        check("reset_out", E0, E0);

        // Load r3 in stage two, ADD r5,r3,r1 in decode.
        rst_n = 1'b1;
        check("load_use", ev(2'b00, 2'b00, 1, 1, 0, 0), ev(2'b00, 2'b00, 1, 1, 0, 0));

        // Load moved to stage three: forwards with select 10, no stall.
        ex_valid = 0; ex_reg_wr = 0; ex_is_load = 0; ex_rd = '0;
        mem_valid = 1; mem_reg_wr = 1; mem_rd = 4'd3;
        check("load_fwd_mem", ev(2'b10, 2'b00, 0, 0, 0, 0), ev(2'b10, 2'b00, 0, 0, 0, 0));

        // Both stages write r2: stage two wins.
        ex_valid = 1; ex_reg_wr = 1; ex_is_load = 0; ex_rd = 4'd2;
        mem_rd = 4'd2; id_rs1 = 4'd2; id_rs2 = 4'd2;
        check("fwd_ex_prio", ev(2'b01, 2'b01, 0, 0, 0, 0), ev(2'b01, 2'b01, 0, 0, 0, 0));

        // Stage two targets r0: falls through to stage three.
        ex_rd = 4'd0;
        check("fwd_ex_r0", ev(2'b10, 2'b10, 0, 0, 0, 0), ev(2'b10, 2'b10, 0, 0, 0, 0));

        // Load to r0 with r0 sources: no hazard, no forwarding.
        ex_is_load = 1; mem_rd = 4'd0; id_rs1 = 4'd0; id_rs2 = 4'd0;
        check("load_r0", E0, E0);

        // Load to r4, decode names r4 but does not read it.
        ex_rd = 4'd4; id_rs1 = 4'd4; id_rs2 = 4'd4; id_use1 = 0; id_use2 = 0;
        check("load_unused", E0, E0);

        // rs2-only load-use.
        id_use2 = 1; id_rs1 = 4'd7;
        check("load_use_rs2", ev(2'b00, 2'b00, 1, 1, 0, 0), ev(2'b00, 2'b00, 1, 1, 0, 0));

        // MUL accepted at this edge.
        idle();
        id_valid = 1; id_multi = 1;
        check("mul_accept", E0, E0);
        id_multi = 0;
        for (int i = 0; i < 3; i++) begin
            check("mul_busy", ev(2'b00, 2'b00, 1, 0, 1, 0), E0);
        end
        // Back-to-back MUL accepted on the first non-stalled cycle.
        id_multi = 1;
        check("mul_release", E0, E0);

        // HALT waits in decode while MULTI holds; MC=1 instance accepts now.
        id_multi = 0; id_halt = 1;
        check("halt_wait", ev(2'b00, 2'b00, 1, 0, 1, 0), E0);
        check("halt_wait", ev(2'b00, 2'b00, 1, 0, 1, 0), ev(2'b00, 2'b00, 0, 1, 0, 0));
        check("halt_wait", ev(2'b00, 2'b00, 1, 0, 1, 0), ev(2'b00, 2'b00, 0, 1, 0, 0));
        check("halt_accept", E0, ev(2'b00, 2'b00, 1, 0, 0, 1));
        check("drain", ev(2'b00, 2'b00, 0, 1, 0, 0), ev(2'b00, 2'b00, 1, 0, 0, 1));
        check("drain", ev(2'b00, 2'b00, 0, 1, 0, 0), ev(2'b00, 2'b00, 1, 0, 0, 1));

        // Halted: forwarding pattern on inputs must still give 00.
        idle();
        ex_valid = 1; ex_reg_wr = 1; ex_rd = 4'd2;
        mem_valid = 1; mem_reg_wr = 1; mem_rd = 4'd2;
        id_valid = 1; id_rs1 = 4'd2; id_rs2 = 4'd2; id_use1 = 1; id_use2 = 1; id_multi = 1;
        for (int i = 0; i < 100; i++) begin
            check("halted", ev(2'b00, 2'b00, 1, 0, 0, 1), ev(2'b00, 2'b00, 1, 0, 0, 1));
        end

        // Reset clears the sticky halt.
        idle();
        rst_n = 1'b0;
        check("halt_reset", E0, E0);
        rst_n = 1'b1;
        check("post_halt_run", E0, E0);

        // Reset in the second MULTI cycle.
        id_valid = 1; id_multi = 1;
        check("mul2_accept", E0, E0);
        id_multi = 0; id_valid = 0;
        check("mul2_busy", ev(2'b00, 2'b00, 1, 0, 1, 0), E0);
        rst_n = 1'b0;
        check("mul2_reset", E0, E0);
        rst_n = 1'b1;
        check("mul2_after", E0, E0);
        check("mul2_after2", E0, E0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
